// File: rtl/pll_drp_reconf_pkg.sv
// ============================================================================
// pll_drp_reconf_pkg : FSM states, DRP address map and merge helper
// Rev 1.0
// ============================================================================
`default_nettype none

package pll_drp_reconf_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ASSERT_RST = 4'd1,
    ST_READ       = 4'd2,
    ST_WAIT_RD    = 4'd3,
    ST_WRITE      = 4'd4,
    ST_WAIT_WR    = 4'd5,
    ST_NEXT       = 4'd6,
    ST_RELEASE    = 4'd7,
    ST_WAIT_LOCK  = 4'd8,
    ST_DONE       = 4'd9
  } state_t;

  // 7-series PLL DRP register addresses
  localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT0_REG1  = 7'h08;
  localparam logic [DRP_ADDR_W-1:0] ADDR_CLKOUT0_REG2  = 7'h09;
  localparam logic [DRP_ADDR_W-1:0] ADDR_CLKFBOUT_REG1 = 7'h14;
  localparam logic [DRP_ADDR_W-1:0] ADDR_CLKFBOUT_REG2 = 7'h15;
  localparam logic [DRP_ADDR_W-1:0] ADDR_DIVCLK        = 7'h16;
  localparam logic [DRP_ADDR_W-1:0] ADDR_LOCK1         = 7'h18;
  localparam logic [DRP_ADDR_W-1:0] ADDR_LOCK2         = 7'h19;
  localparam logic [DRP_ADDR_W-1:0] ADDR_LOCK3         = 7'h1A;
  localparam logic [DRP_ADDR_W-1:0] ADDR_FILT1         = 7'h4E;
  localparam logic [DRP_ADDR_W-1:0] ADDR_FILT2         = 7'h4F;

  // Mask bit 1 keeps the read-back bit, 0 takes the new bit.
  function automatic logic [DRP_DATA_W-1:0] drp_merge(
    input logic [DRP_DATA_W-1:0] rd,
    input logic [DRP_DATA_W-1:0] mask,
    input logic [DRP_DATA_W-1:0] data
  );
    return (rd & mask) | (data & ~mask);
  endfunction

  function automatic logic holds_pll_rst(input state_t s);
    return s inside {ST_ASSERT_RST, ST_READ, ST_WAIT_RD, ST_WRITE, ST_WAIT_WR, ST_NEXT};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_drp_reconf_if.sv
// ============================================================================
// pll_drp_reconf_if : start handshake, table lookup, DRP and PLL control
// Rev 1.0
// ============================================================================
`default_nettype none

interface pll_drp_reconf_if #(
  parameter int IDX_W = 5
) ();
  import pll_drp_reconf_pkg::*;

  logic                  sen;
  logic                  srdy;
  logic                  busy;
  logic                  err;
  logic [IDX_W-1:0]      cfg_idx;
  logic [DRP_ADDR_W-1:0] cfg_addr;
  logic [DRP_DATA_W-1:0] cfg_mask;
  logic [DRP_DATA_W-1:0] cfg_data;
  logic [DRP_ADDR_W-1:0] daddr;
  logic                  den;
  logic                  dwe;
  logic [DRP_DATA_W-1:0] di;
  logic [DRP_DATA_W-1:0] drp_do;
  logic                  drdy;
  logic                  pll_rst;
  logic                  locked;

  modport master (
    input  sen, cfg_addr, cfg_mask, cfg_data, drp_do, drdy, locked,
    output srdy, busy, err, cfg_idx, daddr, den, dwe, di, pll_rst
  );

  modport slave (
    output sen, cfg_addr, cfg_mask, cfg_data, drp_do, drdy, locked,
    input  srdy, busy, err, cfg_idx, daddr, den, dwe, di, pll_rst
  );

endinterface

`default_nettype wire

// File: rtl/pll_drp_reconf_timer.sv
// ============================================================================
// drp_timer : loadable down-counter, expired while the count sits at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module drp_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pll_drp_reconf.sv
// ============================================================================
// pll_drp_reconf : holds PLL in reset, read-modify-writes the DRP table,
//                  releases reset and waits for lock with timeouts
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_drp_reconf
  import pll_drp_reconf_pkg::*;
#(
  parameter int N_REGS       = 23,
  parameter int IDX_W        = 5,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input logic               clk,
  input logic               rst,
  pll_drp_reconf_if.master  bus
);

  localparam int                CNT_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  DRDY_LOAD = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REGS - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cfg_idx_q, cfg_idx_d;
  logic [DRP_ADDR_W-1:0] daddr_q, daddr_d;
  logic [DRP_DATA_W-1:0] di_q, di_d;
  logic [DRP_DATA_W-1:0] rd_q, rd_d;
  logic                  err_q, err_d;

  logic                  w_tmr_load;
  logic [CNT_W-1:0]      w_tmr_val;
  logic                  w_tmr_expired;
  logic [DRP_DATA_W-1:0] w_merged;

  assign w_merged = drp_merge(rd_q, bus.cfg_mask, bus.cfg_data);

  // One timer serves the reset hold, each DRDY wait and the lock wait.
  drp_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .expired_o  (w_tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    cfg_idx_d  = cfg_idx_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    rd_d       = rd_q;
    err_d      = err_q;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.sen) begin
          state_d    = ST_ASSERT_RST;
          cfg_idx_d  = '0;
          err_d      = 1'b0;
          w_tmr_load = 1'b1;
          w_tmr_val  = HOLD_LOAD;
        end
      end
      ST_ASSERT_RST: begin
        if (w_tmr_expired) state_d = ST_READ;
      end
      ST_READ: begin
        daddr_d    = bus.cfg_addr;
        w_tmr_load = 1'b1;
        w_tmr_val  = DRDY_LOAD;
        state_d    = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (bus.drdy) begin
          rd_d    = bus.drp_do;
          state_d = ST_WRITE;
        end else if (w_tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_WRITE: begin
        di_d       = w_merged;
        w_tmr_load = 1'b1;
        w_tmr_val  = DRDY_LOAD;
        state_d    = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (bus.drdy) begin
          state_d = ST_NEXT;
        end else if (w_tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end
      ST_NEXT: begin
        if (cfg_idx_q == LAST_IDX) begin
          state_d = ST_RELEASE;
        end else begin
          cfg_idx_d = cfg_idx_q + IDX_W'(1);
          state_d   = ST_READ;
        end
      end
      ST_RELEASE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = LOCK_LOAD;
        state_d    = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A DRP timeout earlier in the run keeps ERR set even if lock follows.
        if (bus.locked) begin
          state_d = ST_DONE;
        end else if (w_tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg_idx_q <= '0;
      daddr_q   <= '0;
      di_q      <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_idx_q <= cfg_idx_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

  // Address and write data come straight from the lookup in their DEN cycle.
  assign bus.daddr   = (state_q == ST_READ)  ? bus.cfg_addr : daddr_q;
  assign bus.di      = (state_q == ST_WRITE) ? w_merged     : di_q;
  assign bus.den     = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign bus.dwe     = (state_q == ST_WRITE);
  assign bus.srdy    = (state_q == ST_DONE);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.err     = err_q;
  assign bus.cfg_idx = cfg_idx_q;
  assign bus.pll_rst = holds_pll_rst(state_q);

endmodule

`default_nettype wire

// File: tb/tb_pll_drp_reconf.sv
// ============================================================================
// tb_pll_drp_reconf : DRP/PLL stub plus scoreboard bench for pll_drp_reconf
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_drp_reconf;
  import pll_drp_reconf_pkg::*;

  localparam int N_REGS       = 3;
  localparam int IDX_W        = 5;
  localparam int RST_HOLD     = 4;
  localparam int DRDY_TIMEOUT = 64;
  localparam int LOCK_TIMEOUT = 200;
  localparam int DRDY_LAT     = 3;
  localparam int LOCK_LAT     = 10;

  typedef struct packed {
    logic             dwe;
    logic [IDX_W-1:0] idx;
    logic [6:0]       addr;
    logic [15:0]      di;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pll_drp_reconf_if #(.IDX_W(IDX_W)) bus ();

  pll_drp_reconf #(
    .N_REGS(N_REGS), .IDX_W(IDX_W), .RST_HOLD(RST_HOLD),
    .DRDY_TIMEOUT(DRDY_TIMEOUT), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0]  tbl_addr [32];
  logic [15:0] tbl_mask [32];
  logic [15:0] tbl_data [32];
  logic [15:0] init_val [32];
  logic [15:0] exp_wr   [32];

  assign bus.cfg_addr = tbl_addr[bus.cfg_idx];
  assign bus.cfg_mask = tbl_mask[bus.cfg_idx];
  assign bus.cfg_data = tbl_data[bus.cfg_idx];

  int   errors = 0;
  int   checks = 0;
  acc_t obs_q[$];
  acc_t exp_q[$];

  // Stub controls
  bit         drop_en   = 1'b0;
  logic [6:0] drop_addr = 7'h0;
  bit         spur_read = 1'b0;
  bit         spur_idle = 1'b0;
  bit         hold_unlock = 1'b0;

  // Stub state and monitor counters
  int          lat_cnt = 0;
  int          lock_cnt = 0;
  logic [15:0] resp = 16'h0;
  int          den_cnt = 0;
  int          dwe_cnt = 0;
  int          den_no_rst = 0;
  int          rst_run = 0;
  int          ep_dens = 0;
  int          last_hold = 0;

  function automatic logic [15:0] stub_read(input logic [6:0] a);
    for (int i = 0; i < N_REGS; i++)
      if (tbl_addr[i] == a) return init_val[i];
    return 16'h0000;
  endfunction

  // DRP + PLL stub and access monitor, all on the falling edge
  always @(negedge clk) begin
    acc_t a;
    bus.drdy = 1'b0;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        bus.drdy   = 1'b1;
        bus.drp_do = resp;
      end
    end
    if (bus.pll_rst) rst_run++;
    else begin rst_run = 0; ep_dens = 0; end
    if (bus.den) begin
      a.dwe = bus.dwe; a.idx = bus.cfg_idx; a.addr = bus.daddr; a.di = bus.di;
      obs_q.push_back(a);
      den_cnt++;
      if (bus.dwe) dwe_cnt++;
      if (!bus.pll_rst) den_no_rst++;
      if (ep_dens == 0) last_hold = rst_run - 1;
      ep_dens++;
      resp = bus.dwe ? 16'h0000 : stub_read(bus.daddr);
      if (!(drop_en && !bus.dwe && bus.daddr == drop_addr)) lat_cnt = DRDY_LAT;
      if (spur_read && !bus.dwe) begin
        bus.drdy   = 1'b1;
        bus.drp_do = 16'hDEAD;
      end
    end
    if (spur_idle) begin
      bus.drdy   = 1'b1;
      bus.drp_do = 16'hBEEF;
    end
    if (bus.pll_rst || hold_unlock) begin
      bus.locked = 1'b0;
      lock_cnt   = LOCK_LAT;
    end else if (lock_cnt > 0) lock_cnt--;
    else bus.locked = 1'b1;
  end

  task automatic pulse_sen();
    @(negedge clk); bus.sen = 1'b1;
    @(negedge clk); bus.sen = 1'b0;
  endtask

  task automatic push_entry(input int i, input bit with_write);
    acc_t e;
    e.dwe = 1'b0; e.idx = IDX_W'(i); e.addr = tbl_addr[i]; e.di = 16'h0;
    exp_q.push_back(e);
    if (with_write) begin
      e.dwe = 1'b1; e.di = exp_wr[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_srdy(input int budget, output bit seen, output int cycles,
                           output logic err_at, output logic busy_at, output logic prst_at);
    seen = 1'b0; cycles = 0; err_at = 1'bx; busy_at = 1'bx; prst_at = 1'bx;
    while (!seen && cycles < budget) begin
      @(negedge clk); cycles++;
      if (bus.srdy) begin
        seen = 1'b1; err_at = bus.err; busy_at = bus.busy; prst_at = bus.pll_rst;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.sen = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.srdy !== 1'b0)    begin errors++; $display("FAIL rst_srdy: got %b want 0", bus.srdy); end
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.err !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
    checks++; if (bus.den !== 1'b0)     begin errors++; $display("FAIL rst_den: got %b want 0", bus.den); end
    checks++; if (bus.dwe !== 1'b0)     begin errors++; $display("FAIL rst_dwe: got %b want 0", bus.dwe); end
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL rst_pll_rst: got %b want 0", bus.pll_rst); end
    checks++; if (bus.daddr !== 7'h0)   begin errors++; $display("FAIL rst_daddr: got %h want 00", bus.daddr); end
    checks++; if (bus.di !== 16'h0)     begin errors++; $display("FAIL rst_di: got %h want 0000", bus.di); end
    checks++; if (bus.cfg_idx !== '0)   begin errors++; $display("FAIL rst_cfg_idx: got %0d want 0", bus.cfg_idx); end
    rst = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_basic();
    bit seen; int cyc; logic e_at, b_at, p_at; int d0, w0, n0; acc_t e, o;
    obs_q.delete(); exp_q.delete();
    d0 = den_cnt; w0 = dwe_cnt; n0 = den_no_rst;
    for (int i = 0; i < N_REGS; i++) push_entry(i, 1'b1);
    pulse_sen();
    checks++; if (bus.busy !== 1'b1)    begin errors++; $display("FAIL basic_busy_start: got %b want 1", bus.busy); end
    checks++; if (bus.pll_rst !== 1'b1) begin errors++; $display("FAIL basic_pll_rst_start: got %b want 1", bus.pll_rst); end
    wait_srdy(300, seen, cyc, e_at, b_at, p_at);
    checks++; if (!seen)         begin errors++; $display("FAIL basic_srdy: no SRDY after %0d cycles", cyc); end
    checks++; if (e_at !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", e_at); end
    checks++; if (b_at !== 1'b1) begin errors++; $display("FAIL basic_busy_at_srdy: got %b want 1", b_at); end
    checks++; if (p_at !== 1'b0) begin errors++; $display("FAIL basic_pll_rst_at_srdy: got %b want 0", p_at); end
    @(negedge clk);
    checks++; if (bus.srdy !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL basic_after_srdy: srdy=%b busy=%b want 0/0", bus.srdy, bus.busy); end
    repeat (2) @(negedge clk);
    checks++; if (den_cnt - d0 != 2*N_REGS) begin errors++; $display("FAIL basic_den_count: got %0d want %0d", den_cnt - d0, 2*N_REGS); end
    checks++; if (dwe_cnt - w0 != N_REGS)   begin errors++; $display("FAIL basic_dwe_count: got %0d want %0d", dwe_cnt - w0, N_REGS); end
    checks++; if (last_hold < RST_HOLD)     begin errors++; $display("FAIL basic_rst_hold: got %0d want >=%0d", last_hold, RST_HOLD); end
    checks++; if (den_no_rst != n0)         begin errors++; $display("FAIL basic_den_outside_rst: got %0d want 0", den_no_rst - n0); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_access_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.dwe !== e.dwe || o.idx !== e.idx || o.addr !== e.addr || (e.dwe && o.di !== e.di)) begin
        errors++; $display("FAIL basic_access: got dwe=%b idx=%0d addr=%h di=%h want dwe=%b idx=%0d addr=%h di=%h",
                           o.dwe, o.idx, o.addr, o.di, e.dwe, e.idx, e.addr, e.di);
      end
    end
  endtask

  task automatic test_drdy_timeout();
    bit seen; int cyc; logic e_at, b_at, p_at; acc_t e, o;
    obs_q.delete(); exp_q.delete();
    drop_en = 1'b1; drop_addr = tbl_addr[1];
    push_entry(0, 1'b1);
    push_entry(1, 1'b0);
    pulse_sen();
    wait_srdy(DRDY_TIMEOUT + RST_HOLD + 9 + LOCK_LAT + 25, seen, cyc, e_at, b_at, p_at);
    checks++; if (!seen)         begin errors++; $display("FAIL tmo_srdy: no SRDY after %0d cycles", cyc); end
    checks++; if (e_at !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", e_at); end
    checks++; if (p_at !== 1'b0) begin errors++; $display("FAIL tmo_pll_rst: got %b want 0", p_at); end
    repeat (3) @(negedge clk);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL tmo_err_held: got %b want 1", bus.err); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL tmo_access_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.dwe !== e.dwe || o.idx !== e.idx || o.addr !== e.addr || (e.dwe && o.di !== e.di)) begin
        errors++; $display("FAIL tmo_access: got dwe=%b idx=%0d addr=%h di=%h want dwe=%b idx=%0d addr=%h di=%h",
                           o.dwe, o.idx, o.addr, o.di, e.dwe, e.idx, e.addr, e.di);
      end
    end
    drop_en = 1'b0;
  endtask

  task automatic test_lock_timeout();
    int n, rel, done; acc_t e, o;
    obs_q.delete(); exp_q.delete();
    hold_unlock = 1'b1;
    for (int i = 0; i < N_REGS; i++) push_entry(i, 1'b1);
    pulse_sen();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL lock_err_cleared: got %b want 0", bus.err); end
    n = 0; rel = -1; done = -1;
    while (done < 0 && n < LOCK_TIMEOUT + 200) begin
      @(negedge clk); n++;
      if (rel < 0 && !bus.pll_rst) rel = n;
      if (bus.srdy) begin
        done = n;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL lock_err: got %b want 1", bus.err); end
      end
    end
    checks++;
    if (done < 0 || rel < 0 || done - rel < LOCK_TIMEOUT - 1 || done - rel > LOCK_TIMEOUT + 1) begin
      errors++; $display("FAIL lock_latency: got %0d (release=%0d srdy=%0d) want %0d+-1", done - rel, rel, done, LOCK_TIMEOUT);
    end
    repeat (2) @(negedge clk);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL lock_access_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.dwe !== e.dwe || o.idx !== e.idx || o.addr !== e.addr || (e.dwe && o.di !== e.di)) begin
        errors++; $display("FAIL lock_access: got dwe=%b idx=%0d addr=%h di=%h want dwe=%b idx=%0d addr=%h di=%h",
                           o.dwe, o.idx, o.addr, o.di, e.dwe, e.idx, e.addr, e.di);
      end
    end
    hold_unlock = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_rst_abort();
    bit seen, any_busy; int cyc; logic e_at, b_at, p_at; acc_t e, o; bit found;
    obs_q.delete(); exp_q.delete();
    pulse_sen();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.den) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_first_den: no DEN within 20 cycles"); end
    @(negedge clk); bus.sen = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    checks++; if (bus.srdy !== 1'b0)    begin errors++; $display("FAIL abort_srdy: got %b want 0", bus.srdy); end
    checks++; if (bus.pll_rst !== 1'b0) begin errors++; $display("FAIL abort_pll_rst: got %b want 0", bus.pll_rst); end
    checks++; if (bus.den !== 1'b0 || bus.dwe !== 1'b0) begin errors++; $display("FAIL abort_den_dwe: got %b/%b want 0/0", bus.den, bus.dwe); end
    checks++; if (bus.daddr !== 7'h0 || bus.di !== 16'h0 || bus.cfg_idx !== '0)
      begin errors++; $display("FAIL abort_regs: daddr=%h di=%h idx=%0d want 0", bus.daddr, bus.di, bus.cfg_idx); end
    rst = 1'b0; bus.sen = 1'b0;
    any_busy = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.busy || bus.srdy) any_busy = 1'b1; end
    checks++; if (any_busy) begin errors++; $display("FAIL abort_no_restart: got busy/srdy activity want none"); end
    obs_q.delete();
    for (int i = 0; i < N_REGS; i++) push_entry(i, 1'b1);
    pulse_sen();
    wait_srdy(300, seen, cyc, e_at, b_at, p_at);
    checks++; if (!seen || e_at !== 1'b0) begin errors++; $display("FAIL abort_rerun: seen=%b err=%b want 1/0", seen, e_at); end
    repeat (2) @(negedge clk);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_access_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.dwe !== e.dwe || o.idx !== e.idx || o.addr !== e.addr || (e.dwe && o.di !== e.di)) begin
        errors++; $display("FAIL abort_access: got dwe=%b idx=%0d addr=%h di=%h want dwe=%b idx=%0d addr=%h di=%h",
                           o.dwe, o.idx, o.addr, o.di, e.dwe, e.idx, e.addr, e.di);
      end
    end
  endtask

  task automatic test_spurious();
    bit seen; int cyc; logic e_at, b_at, p_at; int d0, w0; acc_t e, o;
    obs_q.delete(); exp_q.delete();
    spur_idle = 1'b1;
    repeat (3) @(negedge clk);
    spur_idle = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spur_idle_busy: got %b want 0", bus.busy); end
    d0 = den_cnt; w0 = dwe_cnt;
    spur_read = 1'b1;
    for (int i = 0; i < N_REGS; i++) push_entry(i, 1'b1);
    pulse_sen();
    wait_srdy(300, seen, cyc, e_at, b_at, p_at);
    checks++; if (!seen || e_at !== 1'b0) begin errors++; $display("FAIL spur_srdy: seen=%b err=%b want 1/0", seen, e_at); end
    repeat (2) @(negedge clk);
    spur_read = 1'b0;
    checks++; if (den_cnt - d0 != 2*N_REGS) begin errors++; $display("FAIL spur_den_count: got %0d want %0d", den_cnt - d0, 2*N_REGS); end
    checks++; if (dwe_cnt - w0 != N_REGS)   begin errors++; $display("FAIL spur_dwe_count: got %0d want %0d", dwe_cnt - w0, N_REGS); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.dwe !== e.dwe || o.idx !== e.idx || o.addr !== e.addr || (e.dwe && o.di !== e.di)) begin
        errors++; $display("FAIL spur_access: got dwe=%b idx=%0d addr=%h di=%h want dwe=%b idx=%0d addr=%h di=%h",
                           o.dwe, o.idx, o.addr, o.di, e.dwe, e.idx, e.addr, e.di);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      tbl_addr[i] = 7'h0; tbl_mask[i] = 16'h0; tbl_data[i] = 16'h0;
      init_val[i] = 16'h0; exp_wr[i] = 16'h0;
    end
    tbl_addr[0] = ADDR_CLKOUT0_REG1;  tbl_mask[0] = 16'h1000; tbl_data[0] = 16'h0145; init_val[0] = 16'h1F3F; exp_wr[0] = 16'h1145;
    tbl_addr[1] = ADDR_CLKOUT0_REG2;  tbl_mask[1] = 16'hFF00; tbl_data[1] = 16'h00AA; init_val[1] = 16'h1234; exp_wr[1] = 16'h12AA;
    tbl_addr[2] = ADDR_CLKFBOUT_REG1; tbl_mask[2] = 16'h0000; tbl_data[2] = 16'h0041; init_val[2] = 16'h5555; exp_wr[2] = 16'h0041;
    bus.sen = 1'b0;

    test_reset();
    test_basic();
    test_drdy_timeout();
    test_lock_timeout();
    test_rst_abort();
    test_spurious();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
